// File: rtl/fixed_point_accumulator.sv
// Signed Q9.7 accumulator for a sequential Booth multiplier: sums term_count products.
// Build option: define ACC_SATURATE_EN to clamp overflowing adds instead of wrapping.
module fixed_point_accumulator #(
  parameter int TERM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [TERM_W-1:0]        term_count,
  input  logic signed [15:0]       product,
  input  logic                     product_overflow,
  input  logic                     product_finish,
  output logic signed [15:0]       sum,
  output logic                     sum_valid,
  output logic                     overflow_flag,
  output logic                     busy
);

`ifdef ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_finish_q;
  logic signed [15:0]      r_sum;
  logic                    r_ovf;
  logic [TERM_W-1:0]       r_remaining;

  logic                    w_accept;
  logic                    w_take;
  logic signed [16:0]      w_sum_ext;
  logic                    w_add_ovf;
  logic signed [15:0]      w_sum_next;

  // The 17-bit sum is exact, so on overflow its bit 16 carries the true sign.
  function automatic logic signed [15:0] fit16(input logic signed [16:0] s,
                                               input logic             ovf);
    logic signed [15:0] r;
    r = s[15:0];
    if (SAT_EN && ovf) begin
      r = s[16] ? 16'sh8000 : 16'sh7FFF;
    end
    return r;
  endfunction

  function automatic logic add_overflow(input logic a_sign, input logic b_sign,
                                        input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

  assign w_accept   = product_finish & ~r_finish_q;
  assign w_take     = w_accept && (r_state == S_ACCUM);
  assign w_sum_ext  = {r_sum[15], r_sum} + {product[15], product};
  assign w_add_ovf  = add_overflow(r_sum[15], product[15], w_sum_ext[15]);
  assign w_sum_next = fit16(w_sum_ext, w_add_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new start always wins, whatever state the block is in.
  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = (term_count != '0) ? S_ACCUM : S_DONE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_ACCUM: if (w_accept && (r_remaining == TERM_W'(1))) w_next_state = S_DONE;
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    sum_valid = 1'b0;
    case (r_state)
      S_ACCUM: busy      = 1'b1;
      S_DONE:  sum_valid = 1'b1;
      default: ;
    endcase
  end

  // finish_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_finish_q  <= 1'b1;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_finish_q <= product_finish;
      if (start) begin
        r_sum       <= '0;
        r_ovf       <= 1'b0;
        r_remaining <= term_count;
      end else if (w_take) begin
        r_sum <= w_sum_next;
        r_ovf <= r_ovf | product_overflow | w_add_ovf;
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - TERM_W'(1);
        end
      end
    end
  end

  assign sum           = r_sum;
  assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed bench for fixed_point_accumulator; expectations follow ACC_SATURATE_EN if defined.
module tb_fixed_point_accumulator;

  localparam int TERM_W = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [TERM_W-1:0] term_count;
  logic [15:0]       product;
  logic              product_overflow;
  logic              product_finish;
  logic [15:0]       sum;
  logic              sum_valid;
  logic              overflow_flag;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int busy_cnt = 0;
  int vld_base;
  int busy_base;

  fixed_point_accumulator #(.TERM_W(TERM_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .term_count       (term_count),
    .product          (product),
    .product_overflow (product_overflow),
    .product_finish   (product_finish),
    .sum              (sum),
    .sum_valid        (sum_valid),
    .overflow_flag    (overflow_flag),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sum_valid) vld_cnt++;
    if (busy)      busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [TERM_W-1:0] tc);
    start      = 1'b1;
    term_count = tc;
    tick();
    start      = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] p, input logic ov);
    product          = p;
    product_overflow = ov;
    product_finish   = 1'b1;
    tick();
    product_finish   = 1'b0;
    product_overflow = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    term_count       = '0;
    product          = '0;
    product_overflow = 1'b0;
    product_finish   = 1'b0;
    repeat (2) tick();
    chk("rst_sum",   sum, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_ovf",   overflow_flag, 0);
    chk("rst_busy",  busy, 0);
    rst_n = 1'b1;
    tick();

    // three terms: 1.0 + 2.0 - 1.0 = 2.0
    vld_base = vld_cnt;
    do_start(3);
    chk("t3_busy", busy, 1);
    pulse(16'h0080, 1'b0); tick();
    pulse(16'h0100, 1'b0); tick();
    chk("t3_mid_sum", sum, 16'h0180);
    pulse(16'hFF80, 1'b0);
    chk("t3_valid", sum_valid, 1);
    chk("t3_sum",   sum, 16'h0100);
    chk("t3_ovf",   overflow_flag, 0);
    chk("t3_busy_done", busy, 0);
    tick();
    chk("t3_valid_drop", sum_valid, 0);
    chk("t3_sum_hold",   sum, 16'h0100);
    chk("t3_pulses",     vld_cnt - vld_base, 1);

    // positive overflow
    do_start(2);
    pulse(16'h7000, 1'b0); tick();
    pulse(16'h2000, 1'b0);
    chk("pos_valid", sum_valid, 1);
`ifdef ACC_SATURATE_EN
    chk("pos_sum", sum, 16'h7FFF);
`else
    chk("pos_sum", sum, 16'h9000);
`endif
    chk("pos_ovf", overflow_flag, 1);
    tick(); tick();
    chk("pos_ovf_hold", overflow_flag, 1);

    // zero terms clears and completes immediately
    busy_base = busy_cnt;
    do_start(0);
    chk("z_valid", sum_valid, 1);
    chk("z_sum",   sum, 0);
    chk("z_ovf",   overflow_flag, 0);
    chk("z_busy",  busy, 0);
    tick();
    chk("z_valid_drop", sum_valid, 0);
    chk("z_busy_never", busy_cnt - busy_base, 0);

    // negative overflow
    do_start(2);
    pulse(16'h8000, 1'b0); tick();
    chk("neg_first_ovf", overflow_flag, 0);
    pulse(16'hFF80, 1'b0);
`ifdef ACC_SATURATE_EN
    chk("neg_sum", sum, 16'h8000);
`else
    chk("neg_sum", sum, 16'h7F80);
`endif
    chk("neg_ovf", overflow_flag, 1);
    tick();

    // long finish level counts once; multiplier overflow is sticky
    do_start(2);
    product          = 16'h0080;
    product_overflow = 1'b0;
    product_finish   = 1'b1;
    repeat (10) tick();
    chk("hold_busy", busy, 1);
    chk("hold_sum",  sum, 16'h0080);
    product_finish = 1'b0;
    tick();
    pulse(16'h0080, 1'b1);
    chk("hold_valid", sum_valid, 1);
    chk("hold_sum_final", sum, 16'h0100);
    chk("hold_ovf", overflow_flag, 1);
    tick();

    // accepts outside ACCUM are ignored
    pulse(16'h1234, 1'b0); tick();
    chk("idle_sum",   sum, 16'h0100);
    chk("idle_valid", sum_valid, 0);

    // reset mid-accumulation
    vld_base = vld_cnt;
    do_start(3);
    pulse(16'h0080, 1'b0); tick();
    chk("mr_sum_pre", sum, 16'h0080);
    product        = 16'h0200;
    product_finish = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sum",   sum, 0);
    chk("mr_busy",  busy, 0);
    chk("mr_valid", sum_valid, 0);
    chk("mr_ovf",   overflow_flag, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(1);
    tick(); tick();
    chk("mr_no_accept_busy", busy, 1);
    chk("mr_no_accept_sum",  sum, 0);
    product_finish = 1'b0;
    tick();
    pulse(16'h0200, 1'b0);
    chk("mr_valid_after", sum_valid, 1);
    chk("mr_sum_after",   sum, 16'h0200);
    tick();
    chk("mr_pulses", vld_cnt - vld_base, 1);

    // start wins over a coincident accept
    do_start(2);
    pulse(16'h0080, 1'b0); tick();
    product        = 16'h0100;
    product_finish = 1'b1;
    start          = 1'b1;
    term_count     = 2;
    tick();
    start          = 1'b0;
    product_finish = 1'b0;
    chk("sw_sum",  sum, 0);
    chk("sw_busy", busy, 1);
    tick();
    pulse(16'h0040, 1'b0);
    chk("sw_busy_mid",  busy, 1);
    chk("sw_valid_mid", sum_valid, 0);
    tick();
    pulse(16'h0040, 1'b0);
    chk("sw_valid", sum_valid, 1);
    chk("sw_sum_final", sum, 16'h0080);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
